// File: rtl/thro_ctrl_pkg.sv
// Shared types, default parameters and the slew helper for the throttle ramp controller.
// The FAILSAFE state exists only when THRO_FAILSAFE_EN is defined.
package thro_ctrl_pkg;

  typedef logic [7:0] thro_t;

  localparam int unsigned DEF_RAMP_DIV = 4;
  localparam int unsigned DEF_STEP     = 2;
  localparam int unsigned DEF_ARM_HOLD = 8;
  localparam int unsigned DEF_TIMEOUT  = 100;

`ifdef THRO_FAILSAFE_EN
  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARM_WAIT = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARM_WAIT = 2'd1,
    ST_ARMED    = 2'd2
  } state_e;
`endif

  // Move cur toward tgt by at most step; lands exactly on tgt, so it never overshoots or wraps.
  function automatic thro_t ramp_step(thro_t cur, thro_t tgt, thro_t step);
    if (tgt > cur) begin
      return (thro_t'(tgt - cur) > step) ? thro_t'(cur + step) : tgt;
    end else begin
      return (thro_t'(cur - tgt) > step) ? thro_t'(cur - step) : tgt;
    end
  endfunction

endpackage

// File: rtl/thro_ramp_ctrl_if.sv
// Command and status bundle of the throttle ramp controller, plus the FSM debug state.
interface thro_ramp_ctrl_if;
  import thro_ctrl_pkg::*;

  // cmd_valid qualifies cmd_thro in the same cycle; there is no ready, every valid cycle is taken.
  logic   cmd_valid;
  thro_t  cmd_thro;
  logic   arm_req;
  logic   disarm_req;
  thro_t  thro_rec_val;
  thro_t  motor_1_offset;
  thro_t  motor_2_offset;
  thro_t  motor_3_offset;
  thro_t  motor_4_offset;
  logic   offset_upd;
  logic   armed;
  logic   failsafe;
  state_e dbg_state;

  modport master (
    output cmd_valid, cmd_thro, arm_req, disarm_req,
    input  thro_rec_val, motor_1_offset, motor_2_offset, motor_3_offset, motor_4_offset,
    input  offset_upd, armed, failsafe, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_thro, arm_req, disarm_req,
    output thro_rec_val, motor_1_offset, motor_2_offset, motor_3_offset, motor_4_offset,
    output offset_upd, armed, failsafe, dbg_state
  );

endinterface

// File: rtl/thro_offset_gen.sv
// Combinational per-motor offset mix derived from the slew-limited throttle.
module thro_offset_gen
  import thro_ctrl_pkg::*;
(
  input  thro_t thro_rec_val,
  output thro_t motor_1_offset,
  output thro_t motor_2_offset,
  output thro_t motor_3_offset,
  output thro_t motor_4_offset
);

  // Fixed fractional trims: 1, 7/8, 3/4 and 1/2 of the throttle; all stay within 0..thro.
  assign motor_1_offset = thro_rec_val;
  assign motor_2_offset = thro_rec_val - (thro_rec_val >> 3);
  assign motor_3_offset = (thro_rec_val >> 1) + (thro_rec_val >> 2);
  assign motor_4_offset = thro_rec_val >> 1;

endmodule

// File: rtl/thro_ramp_ctrl.sv
// Arming sequencer and slew-limited throttle ramp with registered motor offsets.
// Optional timeout failsafe is built when THRO_FAILSAFE_EN is defined.
module thro_ramp_ctrl
  import thro_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned ARM_HOLD = DEF_ARM_HOLD,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input logic             clk,
  input logic             rst,
  thro_ramp_ctrl_if.slave bus
);

  if (RAMP_DIV < 1 || STEP < 1 || STEP > 255 || ARM_HOLD < 1 || TIMEOUT < 1) begin : g_param_check
    $error("thro_ramp_ctrl: parameter out of range");
  end

  localparam thro_t STEP_T = thro_t'(STEP);

  state_e      state_q, state_d;
  thro_t       target_q, target_d;
  thro_t       thro_q, thro_d;
  logic [31:0] div_q, div_d;
  logic [31:0] arm_cnt_q, arm_cnt_d;
  logic        armed_q, armed_d;
  thro_t       m1_q, m2_q, m3_q, m4_q;
  thro_t       gen_m1, gen_m2, gen_m3, gen_m4;
  logic        upd_q, upd_d;
  logic        tick;
`ifdef THRO_FAILSAFE_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        fs_q, fs_d;
`endif

  thro_offset_gen u_offset_gen (
    .thro_rec_val   (thro_q),
    .motor_1_offset (gen_m1),
    .motor_2_offset (gen_m2),
    .motor_3_offset (gen_m3),
    .motor_4_offset (gen_m4)
  );

  assign tick = (div_q == RAMP_DIV - 1);

  always_comb begin
    state_d   = state_q;
    target_d  = bus.cmd_valid ? bus.cmd_thro : target_q;
    thro_d    = thro_q;
    div_d     = div_q;
    arm_cnt_d = arm_cnt_q;
`ifdef THRO_FAILSAFE_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      ST_DISARMED: begin
        thro_d    = '0;
        div_d     = '0;
        arm_cnt_d = '0;
        if (!bus.disarm_req && bus.arm_req && target_q == '0) state_d = ST_ARM_WAIT;
      end
      ST_ARM_WAIT: begin
        if (bus.disarm_req || target_q != '0) begin
          state_d = ST_DISARMED;
        end else if (arm_cnt_q == ARM_HOLD) begin
          state_d = ST_ARMED;
          div_d   = '0;
`ifdef THRO_FAILSAFE_EN
          to_cnt_d = '0;
`endif
        end else begin
          arm_cnt_d = arm_cnt_q + 32'd1;
        end
      end
      ST_ARMED: begin
        if (bus.disarm_req) begin
          state_d = ST_DISARMED;
          thro_d  = '0;
        end else begin
          div_d = tick ? '0 : div_q + 32'd1;
          if (tick) thro_d = ramp_step(thro_q, target_q, STEP_T);
`ifdef THRO_FAILSAFE_EN
          to_cnt_d = bus.cmd_valid ? '0 : to_cnt_q + 32'd1;
          if (!bus.cmd_valid && to_cnt_q == TIMEOUT - 1) state_d = ST_FAILSAFE;
`endif
        end
      end
`ifdef THRO_FAILSAFE_EN
      // Effective target is forced to 0 here; the divider keeps its phase from ARMED.
      ST_FAILSAFE: begin
        if (bus.disarm_req || thro_q == '0) begin
          state_d = ST_DISARMED;
          thro_d  = '0;
        end else begin
          div_d = tick ? '0 : div_q + 32'd1;
          if (tick) thro_d = ramp_step(thro_q, '0, STEP_T);
        end
      end
`endif
      default: begin
        state_d = ST_DISARMED;
        thro_d  = '0;
      end
    endcase
    armed_d = (state_d == ST_ARMED);
`ifdef THRO_FAILSAFE_EN
    fs_d    = (state_d == ST_FAILSAFE);
`endif
  end

  // Offsets track thro_q one edge later; the pulse marks a change of the registered set.
  assign upd_d = ({gen_m1, gen_m2, gen_m3, gen_m4} != {m1_q, m2_q, m3_q, m4_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_DISARMED;
      target_q  <= '0;
      thro_q    <= '0;
      div_q     <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      m1_q      <= '0;
      m2_q      <= '0;
      m3_q      <= '0;
      m4_q      <= '0;
      upd_q     <= 1'b0;
`ifdef THRO_FAILSAFE_EN
      to_cnt_q  <= '0;
      fs_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      thro_q    <= thro_d;
      div_q     <= div_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      m1_q      <= gen_m1;
      m2_q      <= gen_m2;
      m3_q      <= gen_m3;
      m4_q      <= gen_m4;
      upd_q     <= upd_d;
`ifdef THRO_FAILSAFE_EN
      to_cnt_q  <= to_cnt_d;
      fs_q      <= fs_d;
`endif
    end
  end

  assign bus.thro_rec_val   = thro_q;
  assign bus.motor_1_offset = m1_q;
  assign bus.motor_2_offset = m2_q;
  assign bus.motor_3_offset = m3_q;
  assign bus.motor_4_offset = m4_q;
  assign bus.offset_upd     = upd_q;
  assign bus.armed          = armed_q;
  assign bus.dbg_state      = state_q;
`ifdef THRO_FAILSAFE_EN
  assign bus.failsafe       = fs_q;
`else
  assign bus.failsafe       = 1'b0;
`endif

endmodule

// File: doc/thro_ramp_ctrl.md
THRO_RAMP_CTRL -- requirements
Module: thro_ramp_ctrl

Interface
REQ-001 SHALL provide parameter RAMP_DIV, default 4, meaning clock cycles per ramp tick (>=1).
REQ-002 SHALL provide parameter STEP, default 2, meaning maximum thro_rec_val change per tick (1..255).
REQ-003 SHALL provide parameter ARM_HOLD, default 8, meaning cycles the target must stay 0 before arming (>=1).
REQ-004 SHALL provide parameter TIMEOUT, default 100, meaning cycles without cmd_valid before failsafe (>=1).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1  cmd_thro is valid this cycle.
REQ-008 SHALL have port cmd_thro  input  8  requested throttle.
REQ-009 SHALL have port arm_req  input  1  arm request, sampled each cycle.
REQ-010 SHALL have port disarm_req  input  1  disarm request, sampled each cycle.
REQ-011 SHALL have port thro_rec_val  output  8  slew-limited throttle fed to thro_offset_gen.
REQ-012 SHALL have ports motor_1_offset..motor_4_offset  output  8 each  registered motor offsets.
REQ-013 SHALL have port offset_upd  output  1  one-cycle pulse when the offsets change.
REQ-014 SHALL have ports armed and failsafe  output  1 each  state indicators.

Function
REQ-015 SHALL latch cmd_thro into an 8-bit target register on every cycle in which cmd_valid=1, in all states.
REQ-016 SHALL implement states DISARMED, ARM_WAIT, ARMED and FAILSAFE; armed=1 only in ARMED; failsafe=1 only in FAILSAFE.
REQ-017 DISARMED: thro_rec_val held at 0; arm_req=1 with target==0 -> ARM_WAIT; arm_req with target!=0 is ignored.
REQ-018 ARM_WAIT: count cycles; target!=0 or disarm_req -> DISARMED; ARM_HOLD cycles completed -> ARMED, so armed rises exactly ARM_HOLD+1 edges after the edge sampling arm_req.
REQ-019 ARMED: ramp divider counts 0..RAMP_DIV-1 from 0 on state entry; at each wrap (tick), thro_rec_val moves toward target by min(STEP, |target-thro_rec_val|), never overshooting and never wrapping past 0 or 255.
REQ-020 ARMED: disarm_req -> DISARMED with thro_rec_val=0 on the next edge (immediate cut, no ramp); arm_req is ignored.
REQ-021 When arm_req and disarm_req are both 1 in one cycle, disarm SHALL win in every state.
REQ-022 Offsets SHALL be registered from an internal thro_offset_gen driven by thro_rec_val: a thro_rec_val change at edge N gives new offsets and offset_upd=1 at edge N+1; offset_upd=0 otherwise.

Reset
REQ-023 When rst=1 at an edge, the block SHALL set state DISARMED, target 0, all counters 0, thro_rec_val 0, all motor offsets 0, and offset_upd, armed and failsafe 0; rst overrides every other input.
REQ-024 Reset mid-ramp SHALL produce no offset_upd pulse on the reset edge or on the edge after it.

Configuration
REQ-025 Macro THRO_FAILSAFE_EN defined: TIMEOUT consecutive ARMED cycles without cmd_valid (counter cleared by cmd_valid and on ARMED entry) -> FAILSAFE.
REQ-026 In FAILSAFE the effective target SHALL be 0 and cmd_valid SHALL NOT change it; the ramp continues at the same rate; thro_rec_val==0 -> DISARMED; disarm_req -> DISARMED immediately.
REQ-027 Macro THRO_FAILSAFE_EN undefined: no timeout counter, FAILSAFE state absent, failsafe output tied 0.

Structure
REQ-028 Package thro_ctrl_pkg SHALL hold the state enum, the 8-bit throttle type and the default parameter constants.
REQ-029 SHALL instantiate exactly one sub-module, the existing thro_offset_gen, unmodified; all sequencing SHALL live in thro_ramp_ctrl.

Verification (RAMP_DIV=4, STEP=2, ARM_HOLD=8, TIMEOUT=100)
REQ-030 Arm: cmd_thro=0 valid, pulse arm_req -> armed=1 exactly 9 edges later; thro_rec_val stays 0.
REQ-031 Refused arm: cmd_thro=5 valid, pulse arm_req -> stays DISARMED, armed=0, thro_rec_val=0.
REQ-032 Ramp: armed, cmd_thro=9 -> thro_rec_val 2,4,6,8,9 at 4-cycle intervals, each followed one edge later by offset_upd=1 and the matching offsets; no value above 9.
REQ-033 Disarm mid-ramp: thro_rec_val=6, disarm_req=1 with arm_req=1 -> thro_rec_val=0 and armed=0 next edge, offset_upd=1 the edge after.
REQ-034 Failsafe (macro on): thro_rec_val=20, cmd_valid held 0 for 100 cycles -> failsafe=1, ramp to 0 over 10 ticks (40 cycles), then DISARMED; macro off -> thro_rec_val stays 20.
REQ-035 Reset mid-ramp: rst=1 at thro_rec_val=6 -> all outputs 0 on that edge and no offset_upd on the following edge.
